// File: rtl/cellrv32_npu_instr_dispatcher.sv
// In-order instruction dispatcher for the NPU: queues 80-bit instructions and issues them to the
// weight-load, matrix-multiply and activation units. Optional stall counter: CELLRV32_NPU_DISPATCH_PERF_EN.
module cellrv32_npu_instr_dispatcher #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [79:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  output logic [79:0] wgt_instr_o,
  output logic        wgt_en_o,
  input  logic        wgt_busy_i,
  output logic [79:0] mm_instr_o,
  output logic        mm_en_o,
  input  logic        mm_busy_i,
  output logic [79:0] act_instr_o,
  output logic        act_en_o,
  input  logic        act_busy_i,
  output logic        sync_o,
  output logic        err_o,
  output logic        busy_o
`ifdef CELLRV32_NPU_DISPATCH_PERF_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DISPATCH  = 2'd1;
  localparam logic [1:0] ST_WAIT_SYNC = 2'd2;

  logic [79:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [1:0]       state_reg, state_next;

  logic [79:0] wgt_instr_reg, mm_instr_reg, act_instr_reg;
  logic        wgt_en_reg, mm_en_reg, act_en_reg, sync_reg, err_reg;

  logic        fifo_empty, fifo_full, push, pop;
  logic [79:0] head;
  logic [7:0]  opcode;
  logic        is_sync, is_nop, is_act, is_mm, is_wgt;
  logic        wgt_unit_busy, mm_unit_busy, act_unit_busy;
  logic        issue_wgt, issue_mm, issue_act, sync_next, set_err;

  assign fifo_empty    = (count_reg == '0);
  assign fifo_full     = (count_reg == FULL_CNT);
  assign instr_ready_o = ~rst_i & ~fifo_full;
  assign push          = instr_valid_i & instr_ready_o;

  assign head    = fifo_mem[rd_ptr_reg];
  assign opcode  = head[7:0];
  assign is_sync = (opcode == 8'hFF);
  assign is_nop  = (opcode == 8'h00);
  assign is_act  = opcode[7];
  assign is_mm   = (opcode[7:5] == 3'b001);
  assign is_wgt  = (opcode[7:3] == 5'b00001);

  // An enable issued last edge counts as busy until the unit's own busy flag has had time to rise.
  assign wgt_unit_busy = wgt_busy_i | wgt_en_reg;
  assign mm_unit_busy  = mm_busy_i  | mm_en_reg;
  assign act_unit_busy = act_busy_i | act_en_reg;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    issue_wgt  = 1'b0;
    issue_mm   = 1'b0;
    issue_act  = 1'b0;
    sync_next  = 1'b0;
    set_err    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) state_next = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        if (fifo_empty) begin
          state_next = ST_IDLE;
        end else if (is_sync) begin
          state_next = ST_WAIT_SYNC;
        end else if (is_nop) begin
          pop = 1'b1;
        end else if (is_act) begin
          if (!act_unit_busy && !mm_unit_busy) begin
            issue_act = 1'b1;
            pop       = 1'b1;
          end
        end else if (is_mm) begin
          if (!mm_unit_busy && !wgt_unit_busy) begin
            issue_mm = 1'b1;
            pop      = 1'b1;
          end
        end else if (is_wgt) begin
          // Weights must never change under an in-flight multiply.
          if (!wgt_unit_busy && !mm_unit_busy) begin
            issue_wgt = 1'b1;
            pop       = 1'b1;
          end
        end else begin
          set_err = 1'b1;
          pop     = 1'b1;
        end
      end
      ST_WAIT_SYNC: begin
        if (!wgt_unit_busy && !mm_unit_busy && !act_unit_busy) begin
          sync_next  = 1'b1;
          pop        = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= instr_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      state_reg     <= ST_IDLE;
      wgt_instr_reg <= '0;
      mm_instr_reg  <= '0;
      act_instr_reg <= '0;
      wgt_en_reg    <= 1'b0;
      mm_en_reg     <= 1'b0;
      act_en_reg    <= 1'b0;
      sync_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wgt_en_reg <= issue_wgt;
      mm_en_reg  <= issue_mm;
      act_en_reg <= issue_act;
      sync_reg   <= sync_next;
      if (set_err) err_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // The weight unit expects the two address fields packed as {buff_addr, acc_addr}.
      if (issue_wgt) wgt_instr_reg <= {head[7:0], head[39:8], head[79:56], head[55:40]};
      if (issue_mm)  mm_instr_reg  <= head;
      if (issue_act) act_instr_reg <= head;
    end
  end

  assign wgt_instr_o = wgt_instr_reg;
  assign mm_instr_o  = mm_instr_reg;
  assign act_instr_o = act_instr_reg;
  assign wgt_en_o    = wgt_en_reg;
  assign mm_en_o     = mm_en_reg;
  assign act_en_o    = act_en_reg;
  assign sync_o      = sync_reg;
  assign err_o       = err_reg;
  assign busy_o      = ~fifo_empty | (state_reg != ST_IDLE) |
                       wgt_unit_busy | mm_unit_busy | act_unit_busy;

`ifdef CELLRV32_NPU_DISPATCH_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
    end else if (!fifo_empty && !pop && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_cellrv32_npu_instr_dispatcher.sv
// Scoreboard bench for cellrv32_npu_instr_dispatcher: expected issues are queued at push time
// and matched against enable/sync pulses as they appear.
module tb_cellrv32_npu_instr_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [79:0] wgt_instr, mm_instr, act_instr;
  logic        wgt_en, mm_en, act_en;
  logic        wgt_busy, mm_busy, act_busy;
  logic        sync, err, busy;
`ifdef CELLRV32_NPU_DISPATCH_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int          exp_unit_q [$];
  logic [79:0] exp_instr_q [$];

  always #5 clk = ~clk;

  cellrv32_npu_instr_dispatcher #(.FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_i(instr), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .wgt_instr_o(wgt_instr), .wgt_en_o(wgt_en), .wgt_busy_i(wgt_busy),
    .mm_instr_o(mm_instr), .mm_en_o(mm_en), .mm_busy_i(mm_busy),
    .act_instr_o(act_instr), .act_en_o(act_en), .act_busy_i(act_busy),
    .sync_o(sync), .err_o(err), .busy_o(busy)
`ifdef CELLRV32_NPU_DISPATCH_PERF_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [79:0] actual, input logic [79:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [79:0] mk(input logic [7:0] op, input logic [31:0] len,
                                     input logic [15:0] acc, input logic [23:0] buff);
    return {buff, acc, len, op};
  endfunction

  // Unit codes: 0 weight, 1 matmul, 2 activation, 3 sync, 7 nothing issued.
  function automatic void model(input logic [79:0] ins, output int u, output logic [79:0] o);
    logic [7:0] op;
    op = ins[7:0];
    o  = '0;
    if (op == 8'hFF) u = 3;
    else if (op == 8'h00) u = 7;
    else if (op[7]) begin u = 2; o = ins; end
    else if (op[7:5] == 3'b001) begin u = 1; o = ins; end
    else if (op[7:3] == 5'b00001) begin u = 0; o = {op, ins[39:8], ins[79:56], ins[55:40]}; end
    else u = 7;
  endfunction

  task automatic enqueue(input logic [79:0] ins);
    int u;
    logic [79:0] o;
    model(ins, u, o);
    if (u != 7) begin
      exp_unit_q.push_back(u);
      exp_instr_q.push_back(o);
    end
  endtask

  task automatic push(input logic [79:0] ins);
    int n;
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) check("push_ready_timeout", {79'd0, instr_ready}, 80'd1);
    @(posedge clk);
    enqueue(ins);
    $display("push instr=%h", ins);
    #1 instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_unit_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 80'(exp_unit_q.size()), 80'd0);
  endtask

  always @(negedge clk) begin : monitor
    int u;
    int n;
    logic [79:0] ob;
    if (!rst) begin
      n = int'(wgt_en) + int'(mm_en) + int'(act_en) + int'(sync);
      if (n > 1) check("multi_issue", 80'(n), 80'd1);
      if (n >= 1) begin
        if (wgt_en) begin u = 0; ob = wgt_instr; end
        else if (mm_en) begin u = 1; ob = mm_instr; end
        else if (act_en) begin u = 2; ob = act_instr; end
        else begin u = 3; ob = '0; end
        $display("issue unit=%0d instr=%h", u, ob);
        if (exp_unit_q.size() == 0) begin
          check("spurious_issue", 80'(u), 80'd7);
        end else begin
          check("issue_unit", 80'(u), 80'(exp_unit_q.pop_front()));
          check("issue_instr", ob, exp_instr_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; instr = '0; instr_valid = 1'b0;
    wgt_busy = 1'b0; mm_busy = 1'b0; act_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", {79'd0, instr_ready}, 80'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {79'd0, instr_ready}, 80'd1);
    check("reset_busy", {79'd0, busy}, 80'd0);
    check("reset_err", {79'd0, err}, 80'd0);
    check("reset_wgt_instr", wgt_instr, 80'd0);

    // Load weight: enable two edges after the push edge, packed address field.
    push(mk(8'h08, 32'h0000_0010, 16'hABCD, 24'h123456));
    @(negedge clk);
    @(negedge clk);
    check("lw_en_early", {79'd0, wgt_en}, 80'd0);
    @(negedge clk);
    check("lw_en_latency", {79'd0, wgt_en}, 80'd1);
    check("lw_addr_field", {40'd0, wgt_instr[39:0]}, {40'd0, 40'h123456ABCD});
    drain();

    // Matmul held off while the weight unit is busy.
    push(mk(8'h09, 32'h20, 16'h0001, 24'h000002));
    push(mk(8'h20, 32'h40, 16'h0100, 24'h000200));
    n = 0;
    while (!wgt_en && n < 50) begin @(negedge clk); n++; end
    check("lw2_seen", {79'd0, wgt_en}, 80'd1);
    wgt_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("mm_held", {79'd0, mm_en}, 80'd0);
    end
    wgt_busy = 1'b0;
    @(negedge clk);
    check("mm_after_wgt_idle", {79'd0, mm_en}, 80'd1);
    drain();

    // Activation waits for the MM unit.
    mm_busy = 1'b1;
    push(mk(8'h81, 32'h5, 16'h0010, 24'h000020));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("act_held", {79'd0, act_en}, 80'd0);
    end
    mm_busy = 1'b0;
    @(negedge clk);
    check("act_en", {79'd0, act_en}, 80'd1);
    check("act_opcode", {72'd0, act_instr[7:0]}, 80'h81);
    @(negedge clk);
    check("act_single_pulse", {79'd0, act_en}, 80'd0);
    drain();

    // Queue fills while the weight unit stays busy.
    wgt_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(mk(8'h0A, 32'(i), 16'(i + 1), 24'(i + 2)));
    @(negedge clk);
    check("ready_low_full", {79'd0, instr_ready}, 80'd0);
    instr = mk(8'h0B, 32'h99, 16'h5555, 24'h666666);
    instr_valid = 1'b1;
    @(negedge clk);
    check("ready_still_low", {79'd0, instr_ready}, 80'd0);
    wgt_busy = 1'b0;
    @(negedge clk);
    check("first_issue_frees", {79'd0, wgt_en}, 80'd1);
    check("ready_after_issue", {79'd0, instr_ready}, 80'd1);
    @(posedge clk);
    enqueue(instr);
    $display("push instr=%h", instr);
    #1 instr_valid = 1'b0;
    drain();

    // NOP, illegal opcode and a SYNC gated by the activation unit.
    act_busy = 1'b1;
    push(mk(8'h00, 32'h0, 16'h0, 24'h0));
    push(mk(8'h40, 32'h1, 16'h2, 24'h3));
    push(mk(8'hFF, 32'h0, 16'h0, 24'h0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("sync_held", {79'd0, sync}, 80'd0);
    end
    check("err_set", {79'd0, err}, 80'd1);
    act_busy = 1'b0;
    drain();
    @(negedge clk);
    @(negedge clk);
    check("busy_cleared", {79'd0, busy}, 80'd0);
    check("err_sticky", {79'd0, err}, 80'd1);

    // Reset with three instructions queued.
    wgt_busy = 1'b1;
    for (int i = 0; i < 3; i++) push(mk(8'h0C, 32'(i), 16'hBEEF, 24'h0));
    @(negedge clk);
    rst = 1'b1;
    wgt_busy = 1'b0;
    @(negedge clk);
    exp_unit_q.delete();
    exp_instr_q.delete();
    check("rst_en", {77'd0, wgt_en, mm_en, act_en}, 80'd0);
    check("rst_sync_err", {78'd0, sync, err}, 80'd0);
    check("rst_wgt_instr", wgt_instr, 80'd0);
    check("rst_mm_instr", mm_instr, 80'd0);
    check("rst_act_instr", act_instr, 80'd0);
    check("rst_ready_low", {79'd0, instr_ready}, 80'd0);
    check("rst_busy", {79'd0, busy}, 80'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {79'd0, instr_ready}, 80'd1);
    repeat (10) @(negedge clk);
    check("idle_after_rst", {79'd0, busy}, 80'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cellrv32_npu_instr_dispatcher.md
CELLRV32_NPU_INSTR_DISPATCHER -- requirements
Module: cellrv32_npu_instr_dispatcher

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, instruction queue depth; legal values are powers of two, 2..16.
REQ-002 SHALL have port clk_i  in  1  clock; all logic on the rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port instr_i  in  80  instruction_t bits: opcode[7:0], calc_len[39:8], acc_addr[55:40], buff_addr[79:56].
REQ-005 SHALL have ports instr_valid_i  in  1, and instr_ready_o  out  1; valid/ready push handshake.
REQ-006 SHALL have ports wgt_instr_o  out  80 (weight_instruction_t), wgt_en_o  out  1, and wgt_busy_i  in  1; weight-load unit.
REQ-007 SHALL have ports mm_instr_o  out  80, mm_en_o  out  1, and mm_busy_i  in  1; matrix-multiply unit.
REQ-008 SHALL have ports act_instr_o  out  80, act_en_o  out  1, and act_busy_i  in  1; activation unit.
REQ-009 SHALL have ports sync_o  out  1 (synchronize done pulse), err_o  out  1 (sticky illegal opcode), and busy_o  out  1.

Function
REQ-010 SHALL push instr_i into the FIFO when instr_valid_i and instr_ready_o are both high; instr_ready_o = FIFO not full.
REQ-011 SHALL decode the FIFO head in this priority order: 0xFF SYNC; 0x00 NOP; opcode[7]=1 ACTIVATE (activation type = opcode[3:0]); opcode[7:5]=001 MATMUL; opcode[7:3]=00001 LOAD_WEIGHT; any other value ILLEGAL.
REQ-012 SHALL issue in order, at most one instruction per cycle, and only from the head.
REQ-013 SHALL, on issue, register the instruction on the target *_instr_o and pulse the target *_en_o for exactly one cycle; *_instr_o holds until the next issue to that unit.
REQ-014 SHALL drive wgt_instr_o = {opcode, calc_len, buff_addr, acc_addr} (to_weight_instruction mapping).
REQ-015 SHALL treat a unit as busy when its *_busy_i is high or its *_en_o was high in the previous cycle (one-cycle pending mask).
REQ-016 SHALL issue LOAD_WEIGHT only when the weight unit and the MM unit are idle, so weights are never overwritten mid-multiply.
REQ-017 SHALL issue MATMUL only when the MM unit and the weight unit are idle.
REQ-018 SHALL issue ACTIVATE only when the activation unit and the MM unit are idle.
REQ-019 SHALL retire NOP and ILLEGAL in one cycle with no enable pulse; ILLEGAL also sets err_o, which is cleared only by reset.
REQ-020 SHALL implement the FSM IDLE -> DISPATCH (FIFO not empty) -> WAIT_SYNC (SYNC at head) -> IDLE; WAIT_SYNC leaves when all three units are idle, pulses sync_o for one cycle, and pops SYNC.
REQ-021 SHALL, when a push and a pop occur in the same cycle with the FIFO full, accept the push only on the next cycle, because ready depends on the registered full flag.
REQ-022 SHALL wrap the read and write pointers modulo FIFO_DEPTH, and SHALL use a count of width clog2(FIFO_DEPTH)+1 to distinguish full from empty.
REQ-023 SHALL drive busy_o = FIFO not empty, or state is not IDLE, or any unit is busy.

Reset
REQ-024 SHALL, with rst_i high at a clock edge, empty the FIFO, set the state to IDLE, and clear all *_en_o, sync_o, err_o, the pending masks and all *_instr_o to 0.
REQ-025 SHALL drive instr_ready_o low while rst_i is high; reset mid-operation discards queued instructions and emits no further enables.

Configuration
REQ-026 SHALL, with macro CELLRV32_NPU_DISPATCH_PERF_EN defined, add output stall_cnt_o  out  32: it counts cycles in which the head is valid but not issued, saturates at 0xFFFFFFFF, and resets to 0.
REQ-027 SHALL, without CELLRV32_NPU_DISPATCH_PERF_EN, omit stall_cnt_o and its counter entirely.

Verification
REQ-028 SHALL cover this case: push LOAD_WEIGHT 0x08 with buff_addr=0x123456, acc_addr=0xABCD, all units idle -> wgt_en_o pulses 2 cycles after the push edge, and wgt_instr_o address field = 0x123456ABCD.
REQ-029 SHALL cover this case: push LOAD_WEIGHT then MATMUL 0x20, with wgt_busy_i high for 10 cycles -> mm_en_o does not pulse until the cycle after wgt_busy_i falls.
REQ-030 SHALL cover this case: push ACTIVATE 0x81 while mm_busy_i is high -> no act_en_o; after mm_busy_i falls, act_en_o pulses once with act_instr_o opcode 0x81.
REQ-031 SHALL cover this case: push 5 instructions into FIFO_DEPTH=4 with all units held busy -> instr_ready_o goes low after the 4th push, and the 5th is accepted only after the first issue.
REQ-032 SHALL cover this case: push opcode 0x40, then SYNC 0xFF -> err_o goes high; sync_o pulses once, only after all *_busy_i are low; busy_o then returns to 0.
REQ-033 SHALL cover this case: assert rst_i while 3 instructions are queued -> the next cycle has all outputs 0, instr_ready_o returns to 1 after deassert, and no stale enables appear.
